microprog_trace: RTL and testbench

- Downstream consumer of the microprogram controller's 16-bit ASCII state output.
- Decodes each two-character state name ("Y0".."Y8", "Yk") into a 4-bit code.
- On every state change, timestamps the change and buffers it in a small FIFO, drained through a valid/ready handshake by a debug reader.
- Flags completion, illegal codes and trace overflow.

---
 rtl/microtrace_pkg.sv | 68 ++++++
 rtl/trace_fifo.sv | 60 ++++++
 rtl/microprog_trace.sv | 116 +++++++++++
 tb/tb_microprog_trace.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microtrace_pkg.sv
// Shared constants for the microprogram state tracer: ASCII state names, decoded
// codes, entry layout (entry grows by a dwell field when TRACE_DWELL_EN is defined).
package microtrace_pkg;

  localparam logic [15:0] ASCII_IDLE = 16'h0000;
  localparam logic [15:0] ASCII_Y0   = 16'h5930;
  localparam logic [15:0] ASCII_Y1   = 16'h5931;
  localparam logic [15:0] ASCII_Y2   = 16'h5932;
  localparam logic [15:0] ASCII_Y3   = 16'h5933;
  localparam logic [15:0] ASCII_Y4   = 16'h5934;
  localparam logic [15:0] ASCII_Y5   = 16'h5935;
  localparam logic [15:0] ASCII_Y6   = 16'h5936;
  localparam logic [15:0] ASCII_Y7   = 16'h5937;
  localparam logic [15:0] ASCII_Y8   = 16'h5938;
  localparam logic [15:0] ASCII_YK   = 16'h596B;

  localparam logic [3:0] CODE_Y0   = 4'h0;
  localparam logic [3:0] CODE_Y1   = 4'h1;
  localparam logic [3:0] CODE_Y2   = 4'h2;
  localparam logic [3:0] CODE_Y3   = 4'h3;
  localparam logic [3:0] CODE_Y4   = 4'h4;
  localparam logic [3:0] CODE_Y5   = 4'h5;
  localparam logic [3:0] CODE_Y6   = 4'h6;
  localparam logic [3:0] CODE_Y7   = 4'h7;
  localparam logic [3:0] CODE_Y8   = 4'h8;
  localparam logic [3:0] CODE_YK   = 4'h9;
  localparam logic [3:0] CODE_NONE = 4'hF;

  localparam int CODE_W       = 4;
  localparam int TS_W_DEFAULT = 12;
`ifdef TRACE_DWELL_EN
  localparam int TS_FIELDS = 2;
`else
  localparam int TS_FIELDS = 1;
`endif
  localparam int ENTRY_W = CODE_W + TS_FIELDS * TS_W_DEFAULT;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic [3:0] code;
  } decode_t;

  function automatic int entry_width(input int ts_w);
    return CODE_W + TS_FIELDS * ts_w;
  endfunction

  function automatic decode_t decode_state(input logic [15:0] y);
    decode_t r;
    r.valid   = 1'b0;
    r.illegal = 1'b0;
    r.code    = CODE_NONE;
    if (y == ASCII_IDLE) begin
      r.code = CODE_NONE;
    end else if (y >= ASCII_Y0 && y <= ASCII_Y8) begin
      // low nibble of '0'..'8' is the digit itself
      r.valid = 1'b1;
      r.code  = y[3:0];
    end else if (y == ASCII_YK) begin
      r.valid = 1'b1;
      r.code  = CODE_YK;
    end else begin
      r.illegal = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with extra-MSB pointers, sync clear, and a hold register so the
// read data keeps the last popped entry while the FIFO is empty.
module trace_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     ARst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    count   = wr_q - rd_q;
    do_pop  = pop && !empty && !clr;
    // a simultaneous pop frees the slot, so a full FIFO still accepts the push
    do_push = push && !clr && (!full || do_pop);
    wr_d    = wr_q + {{AW{1'b0}}, do_push};
    rd_d    = rd_q + {{AW{1'b0}}, do_pop};
    hold_d  = do_pop ? mem_q[rd_q[AW-1:0]] : hold_q;
    if (clr) begin
      wr_d   = '0;
      rd_d   = '0;
      hold_d = '0;
    end
    rdata = empty ? hold_q : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge ARst) begin
    if (ARst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      hold_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      hold_q <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/microprog_trace.sv
// Decodes the controller's ASCII state name, timestamps each state change into a FIFO
// and keeps sticky done/overflow/illegal flags. TRACE_DWELL_EN adds per-entry dwell.
module microprog_trace
  import microtrace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 12
) (
  input  logic                   clk,
  input  logic                   ARst,
  input  logic                   clr,
  input  logic [15:0]            y_in,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [3:0]             out_code,
  output logic [TS_W-1:0]        out_ts,
  output logic [TS_W-1:0]        out_dwell,
  output logic [$clog2(DEPTH):0] count,
  output logic                   done,
  output logic                   overflow,
  output logic                   illegal
);

  localparam int EW = entry_width(TS_W);

  decode_t       dec;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [3:0]    prev_code_q, prev_code_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
  logic          illegal_q, illegal_d;
  logic          change, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0] wdata, rdata;

  always_comb begin
    dec         = decode_state(y_in);
    change      = dec.valid && (dec.code != prev_code_q);
    ts_d        = ts_q + {{(TS_W-1){1'b0}}, 1'b1};
    fifo_pop    = out_ready && !fifo_empty;
    fifo_push   = change;
    prev_code_d = change ? dec.code : prev_code_q;
    done_d      = done_q | (change && dec.code == CODE_YK);
    overflow_d  = overflow_q | (change && fifo_full && !fifo_pop);
    illegal_d   = illegal_q | dec.illegal;
    if (clr) begin
      ts_d        = '0;
      fifo_push   = 1'b0;
      prev_code_d = CODE_NONE;
      done_d      = 1'b0;
      overflow_d  = 1'b0;
      illegal_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge ARst) begin
    if (ARst) begin
      ts_q        <= '0;
      prev_code_q <= CODE_NONE;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      ts_q        <= ts_d;
      prev_code_q <= prev_code_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
    end
  end

`ifdef TRACE_DWELL_EN
  logic [TS_W-1:0] last_ts_q, last_ts_d, dwell;

  always_comb begin
    // no previous state since reset/clr means nothing to measure
    dwell     = (prev_code_q == CODE_NONE) ? '0 : (ts_d - last_ts_q);
    last_ts_d = change ? ts_d : last_ts_q;
    if (clr) last_ts_d = '0;
    wdata     = {dec.code, ts_d, dwell};
  end

  always_ff @(posedge clk or posedge ARst) begin
    if (ARst) last_ts_q <= '0;
    else      last_ts_q <= last_ts_d;
  end

  assign out_dwell = rdata[TS_W-1:0];
`else
  assign wdata     = {dec.code, ts_d};
  assign out_dwell = '0;
`endif

  trace_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .ARst  (ARst),
    .clr   (clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign out_valid = !fifo_empty;
  assign out_code  = rdata[EW-1 -: 4];
  assign out_ts    = rdata[EW-5 -: TS_W];
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_microprog_trace.sv
// Directed bench for microprog_trace; expected dwell depends on TRACE_DWELL_EN.
module tb_microprog_trace;

  localparam int DEPTH = 16;
  localparam int TS_W  = 12;

  logic              clk = 1'b0;
  logic              ARst, clr, out_ready;
  logic [15:0]       y_in;
  logic              out_valid, done, overflow, illegal;
  logic [3:0]        out_code;
  logic [TS_W-1:0]   out_ts, out_dwell;
  logic [$clog2(DEPTH):0] count;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  microprog_trace #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .ARst(ARst), .clr(clr), .y_in(y_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_code(out_code), .out_ts(out_ts),
    .out_dwell(out_dwell), .count(count), .done(done),
    .overflow(overflow), .illegal(illegal)
  );

  function automatic logic [15:0] ascii_of(input int n);
    return (n == 9) ? 16'h596B : (16'h5930 + 16'(n));
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    y_in = 16'h0; clr = 1'b0; out_ready = 1'b0; ARst = 1'b1;
    @(posedge clk);
    #2;
    ARst = 1'b0;
  endtask

  task automatic test_reset;
    y_in = 16'h0; clr = 1'b0; out_ready = 1'b0; ARst = 1'b1;
    #3;
    vec++;
    if (out_valid !== 1'b0 || count !== '0 || out_code !== 4'h0 || out_ts !== '0 ||
        out_dwell !== '0 || done !== 1'b0 || overflow !== 1'b0 || illegal !== 1'b0) begin
      errs++;
      $display("FAIL reset: valid=%b count=%0d code=%0h ts=%0d dwell=%0d flags=%b%b%b required all zero",
               out_valid, count, out_code, out_ts, out_dwell, done, overflow, illegal);
    end
  endtask

  task automatic test_controller_path;
    int codes[8] = '{0, 1, 2, 3, 4, 7, 8, 9};
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      y_in = ascii_of(codes[k]);
      step();
      vec++;
      if (out_valid !== 1'b1 || out_code !== 4'(codes[k]) || out_ts !== TS_W'(k + 1)) begin
        errs++;
        $display("FAIL path[%0d]: valid=%b code=%0d ts=%0d required 1 %0d %0d",
                 k, out_valid, out_code, out_ts, codes[k], k + 1);
      end
    end
    for (int c = 0; c < 20; c++) begin
      step();
      vec++;
      if (out_valid !== 1'b0 || count !== '0) begin
        errs++;
        $display("FAIL yk_hold[%0d]: valid=%b count=%0d required 0 0", c, out_valid, count);
      end
    end
    vec++;
    if (done !== 1'b1 || out_code !== 4'd9 || out_ts !== TS_W'(8)) begin
      errs++;
      $display("FAIL path_done: done=%b code=%0d ts=%0d required 1 9 8", done, out_code, out_ts);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      y_in = ascii_of(i % 9);
      step();
    end
    vec++;
    if (count !== 5'd16 || overflow !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL overflow_flags: count=%0d ovf=%b done=%b required 16 1 0", count, overflow, done);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vec++;
      if (out_valid !== 1'b1 || out_code !== 4'(i % 9) || out_ts !== TS_W'(i + 1)) begin
        errs++;
        $display("FAIL drain[%0d]: valid=%b code=%0d ts=%0d required 1 %0d %0d",
                 i, out_valid, out_code, out_ts, i % 9, i + 1);
      end
      step();
    end
    vec++;
    if (out_valid !== 1'b0 || count !== '0 || out_code !== 4'd6 || out_ts !== TS_W'(16)) begin
      errs++;
      $display("FAIL drain_empty: valid=%b count=%0d code=%0d ts=%0d required 0 0 6 16",
               out_valid, count, out_code, out_ts);
    end
    step();
    vec++;
    if (out_valid !== 1'b0 || out_code !== 4'd6 || out_ts !== TS_W'(16)) begin
      errs++;
      $display("FAIL empty_pop_hold: valid=%b code=%0d ts=%0d required 0 6 16",
               out_valid, out_code, out_ts);
    end
  endtask

  task automatic test_full_with_pop;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      y_in = ascii_of(i % 9);
      step();
    end
    vec++;
    if (count !== 5'd16 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL full: count=%0d ovf=%b required 16 0", count, overflow);
    end
    y_in = ascii_of(7);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vec++;
    if (count !== 5'd16 || overflow !== 1'b0 || out_code !== 4'd1 || out_ts !== TS_W'(2)) begin
      errs++;
      $display("FAIL full_push_pop: count=%0d ovf=%b code=%0d ts=%0d required 16 0 1 2",
               count, overflow, out_code, out_ts);
    end
  endtask

  task automatic test_illegal;
    do_reset();
    y_in = ascii_of(0);
    step();
    y_in = 16'h0;
    step();
    vec++;
    if (illegal !== 1'b0 || count !== 5'd1) begin
      errs++;
      $display("FAIL idle: illegal=%b count=%0d required 0 1", illegal, count);
    end
    y_in = 16'h4142;
    step();
    vec++;
    if (illegal !== 1'b1 || count !== 5'd1) begin
      errs++;
      $display("FAIL illegal_ab: illegal=%b count=%0d required 1 1", illegal, count);
    end
    y_in = 16'h0;
    step();
    vec++;
    if (illegal !== 1'b1 || count !== 5'd1) begin
      errs++;
      $display("FAIL illegal_sticky: illegal=%b count=%0d required 1 1", illegal, count);
    end
    y_in = ascii_of(0);
    step();
    vec++;
    if (count !== 5'd1) begin
      errs++;
      $display("FAIL prev_kept: count=%0d required 1", count);
    end
    y_in = ascii_of(1);
    step();
    vec++;
    if (count !== 5'd2) begin
      errs++;
      $display("FAIL after_illegal_push: count=%0d required 2", count);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      y_in = ascii_of(i);
      step();
    end
    vec++;
    if (count !== 5'd5) begin
      errs++;
      $display("FAIL pre_reset: count=%0d required 5", count);
    end
    #2;
    ARst = 1'b1;
    #1;
    vec++;
    if (out_valid !== 1'b0 || count !== '0) begin
      errs++;
      $display("FAIL async_reset: valid=%b count=%0d required 0 0", out_valid, count);
    end
    @(posedge clk);
    #2;
    ARst = 1'b0;
    y_in = ascii_of(0);
    step();
    vec++;
    if (count !== 5'd1 || out_code !== 4'd0 || out_ts !== TS_W'(1)) begin
      errs++;
      $display("FAIL post_reset: count=%0d code=%0d ts=%0d required 1 0 1", count, out_code, out_ts);
    end
  endtask

  task automatic test_clr;
    do_reset();
    y_in = ascii_of(0); step();
    y_in = ascii_of(1); step();
    y_in = ascii_of(9); step();
    vec++;
    if (count !== 5'd3 || done !== 1'b1) begin
      errs++;
      $display("FAIL pre_clr: count=%0d done=%b required 3 1", count, done);
    end
    clr = 1'b1;
    y_in = ascii_of(8);
    step();
    clr = 1'b0;
    vec++;
    if (count !== '0 || out_valid !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL clr: count=%0d valid=%b done=%b required 0 0 0", count, out_valid, done);
    end
    step();
    vec++;
    if (count !== 5'd1 || out_code !== 4'd8 || out_ts !== TS_W'(1)) begin
      errs++;
      $display("FAIL post_clr: count=%0d code=%0d ts=%0d required 1 8 1", count, out_code, out_ts);
    end
  endtask

  task automatic test_dwell;
    logic [TS_W-1:0] exp_dwell;
`ifdef TRACE_DWELL_EN
    exp_dwell = TS_W'(3);
`else
    exp_dwell = '0;
`endif
    do_reset();
    y_in = ascii_of(0);
    step(); step(); step();
    y_in = ascii_of(1);
    step();
    vec++;
    if (count !== 5'd2 || out_code !== 4'd0 || out_dwell !== '0) begin
      errs++;
      $display("FAIL dwell_first: count=%0d code=%0d dwell=%0d required 2 0 0", count, out_code, out_dwell);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vec++;
    if (out_code !== 4'd1 || out_ts !== TS_W'(4) || out_dwell !== exp_dwell) begin
      errs++;
      $display("FAIL dwell_y1: code=%0d ts=%0d dwell=%0d required 1 4 %0d",
               out_code, out_ts, out_dwell, exp_dwell);
    end
  endtask

  initial begin
    test_reset();
    test_controller_path();
    test_overflow();
    test_full_with_pop();
    test_illegal();
    test_async_reset();
    test_clr();
    test_dwell();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
